// File: rtl/tessia_pkg.sv
// tessia_pkg: shared types and default widths for the Tessia data-memory path
package tessia_pkg;
  typedef enum logic [1:0] {IDLE, CPU_RD, HOST_RD} arb_state_t;
  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;
endpackage

// File: rtl/starve_counter.sv
// starve_counter: saturating count of denied host cycles with clear and at_max flag
module starve_counter #(
  parameter int MAX = 4,
  localparam int W = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_max
);
  logic [W-1:0] cnt;
  // count denied cycles, saturating at MAX
  always_ff @(posedge clk) begin
    if (!reset || clr) cnt <= '0;
    else if (inc && !at_max) cnt <= cnt + 1'b1;
  end
  assign at_max = cnt == W'(MAX);
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data RAM between the MEM stage and a host port
module dmem_arbiter
  import tessia_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  arb_state_t state, state_d;
  logic [DATA_W-1:0] cpu_hold, host_hold;
  logic at_max, idle, host_win, cpu_win;
  starve_counter #(.MAX(STARVE_MAX)) u_starve (
    .clk(clk),
    .reset(reset),
    .inc(host_req && !host_win),
    .clr(!host_req || host_win),
    .at_max(at_max)
  );
  // arbitration, RAM mux, handshakes and next state; everything is forced low in reset
  always_comb begin
    idle = reset && state == IDLE;
    host_win = idle && host_req && (!cpu_req || at_max);
    cpu_win = idle && cpu_req && !host_win;
    mem_en = host_win || cpu_win;
    mem_we = host_win ? host_we : cpu_win && cpu_we;
    mem_addr = host_win ? host_addr : cpu_win ? cpu_addr : '0;
    mem_wdata = host_win ? host_wdata : cpu_win ? cpu_wdata : '0;
    host_gnt = host_win;
    host_rvalid = reset && state == HOST_RD;
    cpu_stall = reset && cpu_req && !(cpu_win && cpu_we) && state != CPU_RD;
    cpu_rdata = !reset ? '0 : state == CPU_RD ? mem_rdata : cpu_hold;
    host_rdata = !reset ? '0 : host_rvalid ? mem_rdata : host_hold;
    state_d = state != IDLE ? IDLE : (host_win && !host_we) ? HOST_RD : (cpu_win && !cpu_we) ? CPU_RD : IDLE;
  end
  // state register and read-data holding registers; reset abandons any in-flight read
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cpu_hold <= '0;
      host_hold <= '0;
    end else begin
      state <= state_d;
      if (state == CPU_RD) cpu_hold <= mem_rdata;
      if (state == HOST_RD) host_hold <= mem_rdata;
    end
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares one single-port synchronous data RAM between two requesters: the Tessia pipeline MEM stage (requester 0, "cpu") and a host/loader port (requester 1, "host") used for program/data load and debug readback.
- Sits between the processor's MEM stage and the data RAM.
- Drives a stall back into the pipeline while the cpu access is pending.
- Uses cpu-priority arbitration with a starvation guard for the host.

Parameters:
- ADDR_W, 10, word-address width of the RAM.
- DATA_W, 32, data width.
- STARVE_MAX, 4, consecutive denied host-request cycles before the host wins arbitration.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- cpu_req  in  1  MEM stage access request (load or store).
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  ADDR_W  cpu word address.
- cpu_wdata  in  DATA_W  store data.
- cpu_rdata  out  DATA_W  load data.
- cpu_stall  out  1  freeze pipeline while the cpu access is not yet complete.
- host_req  in  1  host access request, held until granted.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  ADDR_W  host word address.
- host_wdata  in  DATA_W  host write data.
- host_gnt  out  1  one-cycle pulse: host access issued this cycle.
- host_rvalid  out  1  one-cycle pulse: host_rdata valid.
- host_rdata  out  DATA_W  host read data.
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after a read issue.

Behaviour:
- Reset (reset=0 at a clk edge): state IDLE, starvation counter 0, cpu_rdata holding register 0. All outputs are 0, including cpu_stall. An in-flight read is abandoned: no rvalid and no cpu_rdata update.
- States:
  - IDLE: may issue.
  - CPU_RD: cpu read data cycle.
  - HOST_RD: host read data cycle.
  - No issue occurs in CPU_RD or HOST_RD. Both always return to IDLE on the next edge.
- Arbitration, combinational in IDLE:
  - host wins if host_req && (!cpu_req || starve_cnt == STARVE_MAX).
  - Otherwise cpu wins if cpu_req.
  - Otherwise nothing is issued.
- Issue cycle: mem_en=1, and mem_we/addr/wdata are muxed from the winner. mem_* are 0 when nothing is issued.
- cpu write: completes in the issue cycle. cpu_stall=0 that cycle. Latency 0 extra cycles.
- cpu read: cpu_stall=1 in the issue cycle, then go to CPU_RD. In CPU_RD: cpu_stall=0, cpu_rdata = mem_rdata (pass-through), and the holding register loads mem_rdata. Outside CPU_RD, cpu_rdata = holding register.
- cpu_stall = cpu_req && !(cpu granted && cpu_we) && state != CPU_RD.
  - This means stall is asserted while the host holds the RAM, and during HOST_RD.
- host write: host_gnt=1 in the issue cycle. No rvalid.
- host read: host_gnt=1 in the issue cycle, then go to HOST_RD. In HOST_RD: host_rvalid=1, host_rdata=mem_rdata, registered hold afterwards.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) each cycle host_req=1 and the host is not granted.
  - Clears on host grant or when host_req=0.
  - Width is clog2(STARVE_MAX+1).
- Simultaneous requests with starve_cnt < STARVE_MAX: cpu wins and the host counter increments.
- cpu_req=1 in CPU_RD for the same load: the pipeline advances because stall is low. Any new cpu_req in the following IDLE cycle is a new access.
- Requests are ignored (not queued) in CPU_RD and HOST_RD. The requester keeps req high.
- Address and data are passed through with no width arithmetic. Addresses are word addresses; the pipeline supplies ALUResult[ADDR_W+1:2].

Decomposition:
- Shared package tessia_pkg: arb_state_t enum {IDLE, CPU_RD, HOST_RD}, plus localparams for the default ADDR_W/DATA_W.
- One sub-module is natural: starve_counter, a saturating counter with inc/clear and an at_max flag.
- Arbitration and the FSM stay in dmem_arbiter.

Test Plan:
- Reset: hold reset=0 for 3 cycles with cpu_req=host_req=1 -> all outputs 0 and mem_en=0. Release reset -> cpu is issued on the first cycle.
- cpu load only: cpu_req=1, we=0, addr=0x010, RAM[0x010]=0xDEADBEEF -> T0: mem_en=1, cpu_stall=1. T1: cpu_stall=0, cpu_rdata=0xDEADBEEF. T2+: held.
- cpu store only: addr=0x020, wdata=0x12345678 -> same cycle mem_we=1 and cpu_stall=0. A later host read of 0x020 returns 0x12345678 with rvalid 1 cycle after gnt.
- Contention, cpu storing every cycle with host_req=1: the cpu is served 4 cycles, then the host gets gnt on cycle 5 with cpu_stall=1 that cycle. The counter clears and the cpu resumes on cycle 6.
- Host read while cpu idle: host_addr=0x3FF, RAM=0xA5A5A5A5 -> gnt at T0, rvalid with host_rdata=0xA5A5A5A5 at T1. A cpu_req raised at T1 gets stall=1 at T1 and issues at T2.
- Reset mid-read: cpu load issued at T0, reset=0 at T1 -> no cpu_rdata update, host_rvalid=0, state IDLE after release.
